// File: rtl/upper_drain.sv
// Read-side controller for the merge-sort upper-layer shift chain: drains TRAIN_LENGTH words
// from the chain tail into a buffer, then replays them in chain order on a valid/ready stream.
module upper_drain #(
    parameter  int unsigned TRAIN_LENGTH = 3,
    parameter  int unsigned DATA_WIDTH   = 8,
    localparam int unsigned IDX_W        = (TRAIN_LENGTH > 1) ? $clog2(TRAIN_LENGTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] ser_in,
    output logic                  shift_out,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]      out_index,
    output logic                  out_last,
    output logic                  start_err
);

    typedef enum logic [1:0] {StIdle, StDrain, StEmit} state_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(TRAIN_LENGTH - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] buf_q [TRAIN_LENGTH];
    logic [DATA_WIDTH-1:0] buf_d [TRAIN_LENGTH];
    logic                  start_err_q, start_err_d;
    logic                  cnt_at_last;

    assign cnt_at_last = (cnt_q == LastIdx);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        // Any start that does not see IDLE at the sampling edge is rejected, including
        // one coinciding with the final handshake.
        start_err_d = start && (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end
            end
            StDrain: begin
                // Tail word is sampled on the same edge that shifts the chain.
                buf_d[cnt_q] = ser_in;
                if (cnt_at_last) begin
                    state_d = StEmit;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StEmit: begin
                if (out_ready) begin
                    if (cnt_at_last) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            buf_q       <= '{default: '0};
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            start_err_q <= start_err_d;
        end
    end

    always_comb begin
        shift_out = (state_q == StDrain);
        busy      = (state_q != StIdle);
        out_valid = (state_q == StEmit);
        out_data  = '0;
        out_index = '0;
        out_last  = 1'b0;
        if (state_q == StEmit) begin
            out_data  = buf_q[cnt_q];
            out_index = cnt_q;
            out_last  = cnt_at_last;
        end
    end

    assign start_err = start_err_q;

endmodule

// File: tb/tb_upper_drain.sv
// Directed bench for upper_drain: a TRAIN_LENGTH=3 instance and a TRAIN_LENGTH=1 instance,
// each fed by a small shift-chain model.
module tb_upper_drain;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // TRAIN_LENGTH = 3 instance and its chain
    logic       start, out_ready, shift_out, busy, out_valid, out_last, start_err;
    logic [7:0] ser_in, out_data;
    logic [1:0] out_index;
    logic [2:0][7:0] chain, ld_vals;
    logic       ld;

    // TRAIN_LENGTH = 1 instance and its chain
    logic       start1, out_ready1, shift_out1, busy1, out_valid1, out_last1, start_err1;
    logic [7:0] ser_in1, out_data1, chain1, ld_val1;
    logic [0:0] out_index1;
    logic       ld1;

    upper_drain #(.TRAIN_LENGTH(3), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ser_in    (ser_in),
        .shift_out (shift_out),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .start_err (start_err)
    );

    upper_drain #(.TRAIN_LENGTH(1), .DATA_WIDTH(8)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start1),
        .ser_in    (ser_in1),
        .shift_out (shift_out1),
        .busy      (busy1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_data  (out_data1),
        .out_index (out_index1),
        .out_last  (out_last1),
        .start_err (start_err1)
    );

    // Chain model: element 0 is the tail; zeros enter behind the drained data.
    assign ser_in  = chain[0];
    assign ser_in1 = chain1;

    always @(posedge clk) begin
        if (ld) chain <= ld_vals;
        else if (shift_out) chain <= {8'h00, chain[2], chain[1]};
        if (ld1) chain1 <= ld_val1;
        else if (shift_out1) chain1 <= 8'h00;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        ld      = 1'b1;
        ld_vals = {c, b, a};
        tick();
        ld = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({shift_out, busy, out_valid, out_last, start_err} !== 5'b0 ||
            out_data !== 8'h00 || out_index !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: shift=%b busy=%b valid=%b last=%b err=%b data=%h idx=%0d, want all 0",
                     shift_out, busy, out_valid, out_last, start_err, out_data, out_index);
        end
        checks++;
        if ({shift_out1, busy1, out_valid1, out_last1, start_err1} !== 5'b0 ||
            out_data1 !== 8'h00 || out_index1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_tl1: shift=%b busy=%b valid=%b last=%b err=%b data=%h, want all 0",
                     shift_out1, busy1, out_valid1, out_last1, start_err1, out_data1);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int n;
        logic [7:0] exp [3];
        exp = '{8'h11, 8'h22, 8'h33};
        load3(8'h11, 8'h22, 8'h33);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 10 && shift_out; c++) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL basic_shift_len: got %0d cycles, want 3", n);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i] || out_index !== 2'(i) ||
                out_last !== (i == 2)) begin
                errors++;
                $display("FAIL basic_word%0d: valid=%b data=%h idx=%0d last=%b, want 1 %h %0d %b",
                         i, out_valid, out_data, out_index, out_last, exp[i], i, (i == 2));
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_fall: busy=%b valid=%b, want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [3];
        exp = '{8'h11, 8'h22, 8'h33};
        load3(8'h11, 8'h22, 8'h33);
        out_ready = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            for (int s = 0; s < 4; s++) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp[i] || out_index !== 2'(i) ||
                    out_last !== (i == 2)) begin
                    errors++;
                    $display("FAIL bp_stall_w%0d_c%0d: valid=%b data=%h idx=%0d last=%b, want 1 %h %0d %b",
                             i, s, out_valid, out_data, out_index, out_last, exp[i], i, (i == 2));
                end
                tick();
            end
            out_ready = 1'b1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                errors++;
                $display("FAIL bp_accept_w%0d: valid=%b data=%h, want 1 %h",
                         i, out_valid, out_data, exp[i]);
            end
            tick();
            out_ready = 1'b0;
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_extra: valid=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_start_busy();
        int n;
        load3(8'h11, 8'h22, 8'h33);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        n = int'(shift_out);
        tick();
        n += int'(shift_out);
        start = 1'b1;
        tick();
        start = 1'b0;
        n += int'(shift_out);
        checks++;
        if (start_err !== 1'b1) begin
            errors++;
            $display("FAIL sb_err_drain: start_err=%b, want 1", start_err);
        end
        tick();
        n += int'(shift_out);
        checks++;
        if (n !== 3 || start_err !== 1'b0) begin
            errors++;
            $display("FAIL sb_drain_len: shift cycles=%0d err=%b, want 3 0", n, start_err);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11 || out_index !== 2'd0) begin
            errors++;
            $display("FAIL sb_word0: valid=%b data=%h idx=%0d, want 1 11 0",
                     out_valid, out_data, out_index);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (start_err !== 1'b1 || out_data !== 8'h22 || out_index !== 2'd1) begin
            errors++;
            $display("FAIL sb_err_emit: err=%b data=%h idx=%0d, want 1 22 1",
                     start_err, out_data, out_index);
        end
        tick();
        checks++;
        if (start_err !== 1'b0 || out_data !== 8'h33 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL sb_word2: err=%b data=%h last=%b, want 0 33 1",
                     start_err, out_data, out_last);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL sb_done: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [7:0] exp [3];
        exp = '{8'hA0, 8'hB0, 8'hC0};
        load3(8'h11, 8'h22, 8'h33);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (shift_out !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: shift=%b busy=%b valid=%b, want 0 0 0",
                     shift_out, busy, out_valid);
        end
        load3(8'hA0, 8'hB0, 8'hC0);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 10 && shift_out; c++) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL rst_redrain_len: got %0d, want 3", n);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i] || out_index !== 2'(i)) begin
                errors++;
                $display("FAIL rst_word%0d: valid=%b data=%h idx=%0d, want 1 %h %0d",
                         i, out_valid, out_data, out_index, exp[i], i);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        exp = '{8'h01, 8'h02, 8'h03};
        load3(8'h11, 8'h22, 8'h33);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        tick();
        // Final word is up; a start alongside its handshake must be rejected.
        checks++;
        if (out_last !== 1'b1 || out_data !== 8'h33) begin
            errors++;
            $display("FAIL b2b_last: last=%b data=%h, want 1 33", out_last, out_data);
        end
        start = 1'b1;
        tick();
        checks++;
        if (start_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_same_cycle: err=%b busy=%b, want 1 0", start_err, busy);
        end
        ld      = 1'b1;
        ld_vals = {8'h03, 8'h02, 8'h01};
        tick();
        start = 1'b0;
        ld    = 1'b0;
        checks++;
        if (start_err !== 1'b0 || shift_out !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: err=%b shift=%b busy=%b, want 0 1 1",
                     start_err, shift_out, busy);
        end
        tick();
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i] || out_index !== 2'(i)) begin
                errors++;
                $display("FAIL b2b_word%0d: valid=%b data=%h idx=%0d, want 1 %h %0d",
                         i, out_valid, out_data, out_index, exp[i], i);
            end
            tick();
        end
    endtask

    task automatic test_tl1();
        ld1     = 1'b1;
        ld_val1 = 8'h5A;
        tick();
        ld1        = 1'b0;
        out_ready1 = 1'b1;
        start1     = 1'b1;
        tick();
        start1 = 1'b0;
        checks++;
        if (shift_out1 !== 1'b1 || out_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL tl1_drain: shift=%b valid=%b, want 1 0", shift_out1, out_valid1);
        end
        tick();
        checks++;
        if (shift_out1 !== 1'b0 || out_valid1 !== 1'b1 || out_data1 !== 8'h5A ||
            out_last1 !== 1'b1 || out_index1 !== 1'b0) begin
            errors++;
            $display("FAIL tl1_word: shift=%b valid=%b data=%h last=%b idx=%0d, want 0 1 5a 1 0",
                     shift_out1, out_valid1, out_data1, out_last1, out_index1);
        end
        tick();
        checks++;
        if (busy1 !== 1'b0 || out_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL tl1_done: busy=%b valid=%b, want 0 0", busy1, out_valid1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        out_ready  = 1'b0;
        ld         = 1'b0;
        ld_vals    = '0;
        start1     = 1'b0;
        out_ready1 = 1'b0;
        ld1        = 1'b0;
        ld_val1    = 8'h00;
        test_reset();
        test_basic();
        test_backpressure();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        test_tl1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
